// File: rtl/instr_sequencer.sv
// MiniRISC multi-cycle control sequencer.
// FETCH/DECODE/EXEC/MEM/WB with memory timeout trap.
module instr_sequencer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] branch_ctl,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       link_we,
  output logic       flag_we,
  output logic       halted,
  output logic       fault
);

  localparam int CW = (TIMEOUT_CYC > 2) ?
    $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    FAULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;

  logic alu_c;
  logic lw_c;
  logic sw_c;
  logic br_c;
  logic nop_c;
  logic bl_c;

  // Classify the opcode held since DECODE.
  always_comb begin
    alu_c = (op_q[3:2] == 2'b00);
    lw_c  = (op_q == 4'b0100);
    sw_c  = (op_q == 4'b0101);
    nop_c = (op_q == 4'b1110);
    bl_c  = (op_q == 4'b1011);
    br_c  = (op_q >= 4'b0110) &&
            (op_q <= 4'b1101);
  end

  // State, wait counter and opcode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ack) begin
            cnt   <= '0;
            state <= DECODE;
          end else if (cnt == LAST) begin
            state <= FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DECODE: begin
          op_q  <= opcode;
          state <= (opcode == 4'b1111) ?
                   HALT : EXEC;
        end
        EXEC: begin
          if (alu_c)
            state <= WB;
          else if (lw_c || sw_c)
            state <= MEM;
          else
            state <= FETCH;
        end
        MEM: begin
          if (mem_ack) begin
            cnt   <= '0;
            state <= lw_c ? WB : FETCH;
          end else if (cnt == LAST) begin
            state <= FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  // Datapath strobes from state; forced low in reset.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 2'b00;
    reg_we  = 1'b0;
    wb_sel  = 1'b0;
    link_we = 1'b0;
    flag_we = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    if (rst_n) begin
      unique case (state)
        FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        DECODE: ;
        EXEC: begin
          unique case (1'b1)
            alu_c: flag_we = 1'b1;
            nop_c: pc_we   = 1'b1;
            br_c: begin
              pc_we   = 1'b1;
              link_we = bl_c;
              unique case (1'b1)
                !branch_ctl[2]:
                  pc_sel = 2'b00;
                branch_ctl[2] &&
                branch_ctl[1]:
                  pc_sel = 2'b11;
                branch_ctl[2] &&
                !branch_ctl[1] &&
                branch_ctl[0]:
                  pc_sel = 2'b10;
                default:
                  pc_sel = 2'b01;
              endcase
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = sw_c;
          pc_we   = sw_c && mem_ack;
        end
        WB: begin
          reg_we = 1'b1;
          wb_sel = lw_c;
          pc_we  = 1'b1;
        end
        HALT: halted = 1'b1;
        FAULT: begin
          halted = 1'b1;
          fault  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer.
// Per-cycle expected strobes via a queue.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [2:0] branch_ctl;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       reg_we;
  logic       wb_sel;
  logic       link_we;
  logic       flag_we;
  logic       halted;
  logic       fault;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic       wb_sel;
    logic       link_we;
    logic       flag_we;
    logic       halted;
    logic       fault;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    total  = 0;
  int    passed = 0;

  instr_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .branch_ctl(branch_ctl),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .pc_sel(pc_sel),
    .reg_we(reg_we),
    .wb_sel(wb_sel),
    .link_we(link_we),
    .flag_we(flag_we),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic out_t z();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t f(input logic ack);
    out_t o;
    o = '0;
    o.mem_req = 1'b1;
    o.ir_we   = ack;
    return o;
  endfunction

  function automatic out_t e_alu();
    out_t o;
    o = '0;
    o.flag_we = 1'b1;
    return o;
  endfunction

  function automatic out_t e_pc(
    input logic [1:0] sel,
    input logic       lnk
  );
    out_t o;
    o = '0;
    o.pc_we   = 1'b1;
    o.pc_sel  = sel;
    o.link_we = lnk;
    return o;
  endfunction

  function automatic out_t m(
    input logic we,
    input logic ack
  );
    out_t o;
    o = '0;
    o.mem_req = 1'b1;
    o.mem_we  = we;
    o.pc_we   = we & ack;
    return o;
  endfunction

  function automatic out_t wb(input logic ld);
    out_t o;
    o = '0;
    o.reg_we = 1'b1;
    o.wb_sel = ld;
    o.pc_we  = 1'b1;
    return o;
  endfunction

  function automatic out_t hlt(input logic flt);
    out_t o;
    o = '0;
    o.halted = 1'b1;
    o.fault  = flt;
    return o;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.mem_req = mem_req;
    o.mem_we  = mem_we;
    o.ir_we   = ir_we;
    o.pc_we   = pc_we;
    o.pc_sel  = pc_sel;
    o.reg_we  = reg_we;
    o.wb_sel  = wb_sel;
    o.link_we = link_we;
    o.flag_we = flag_we;
    o.halted  = halted;
    o.fault   = fault;
    return o;
  endfunction

  // Drive one cycle of inputs, push the
  // expectation, compare at negedge, then
  // advance to just after the next posedge.
  task automatic cyc(
    input logic [3:0] op,
    input logic [2:0] bc,
    input logic       ack,
    input out_t       e,
    input string      tag
  );
    out_t  got;
    out_t  want;
    string t;
    opcode     = op;
    branch_ctl = bc;
    mem_ack    = ack;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = observe();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %h want %h",
                t, got, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    opcode     = 4'h0;
    branch_ctl = 3'b000;
    mem_ack    = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'h0, 3'b111, 1'b1, z(), "reset");
    rst_n = 1'b1;

    cyc(4'h0, 3'b000, 1'b1, f(1), "alu_c1");
    cyc(4'h0, 3'b000, 1'b0, z(), "alu_c2");
    cyc(4'h0, 3'b000, 1'b0, e_alu(), "alu_c3");
    cyc(4'h0, 3'b000, 1'b0, wb(0), "alu_c4");

    cyc(4'h9, 3'b111, 1'b1, f(1), "bz_f");
    cyc(4'h9, 3'b111, 1'b0, z(), "bz_d");
    cyc(4'h9, 3'b101, 1'b0,
        e_pc(2'b10, 0), "bz_101");

    cyc(4'h9, 3'b111, 1'b1, f(1), "bzn_f");
    cyc(4'h9, 3'b111, 1'b0, z(), "bzn_d");
    cyc(4'h9, 3'b000, 1'b0,
        e_pc(2'b00, 0), "bz_000");

    cyc(4'h6, 3'b000, 1'b1, f(1), "br_f");
    cyc(4'h6, 3'b000, 1'b0, z(), "br_d");
    cyc(4'h6, 3'b111, 1'b0,
        e_pc(2'b11, 0), "br_111");

    cyc(4'hB, 3'b011, 1'b1, f(1), "bl_f");
    cyc(4'hB, 3'b011, 1'b0, z(), "bl_d");
    cyc(4'hB, 3'b100, 1'b0,
        e_pc(2'b01, 1), "bl_100");

    cyc(4'hE, 3'b111, 1'b1, f(1), "nop_f");
    cyc(4'hE, 3'b111, 1'b0, z(), "nop_d");
    cyc(4'hE, 3'b111, 1'b0,
        e_pc(2'b00, 0), "nop_e");

    cyc(4'h4, 3'b000, 1'b1, f(1), "lw_f");
    cyc(4'h4, 3'b000, 1'b0, z(), "lw_d");
    cyc(4'h4, 3'b000, 1'b0, z(), "lw_e");
    for (int i = 0; i < 3; i++)
      cyc(4'h4, 3'b000, 1'b0, m(0, 0), "lw_wait");
    cyc(4'h4, 3'b000, 1'b1, m(0, 1), "lw_ack");
    cyc(4'h4, 3'b000, 1'b0, wb(1), "lw_wb");

    cyc(4'h5, 3'b000, 1'b1, f(1), "sw_f");
    cyc(4'h5, 3'b000, 1'b0, z(), "sw_d");
    cyc(4'h5, 3'b000, 1'b0, z(), "sw_e");
    cyc(4'h5, 3'b000, 1'b1, m(1, 1), "sw_m");

    for (int i = 0; i < 15; i++)
      cyc(4'h1, 3'b000, 1'b0, f(0), "late_wait");
    cyc(4'h1, 3'b000, 1'b1, f(1), "late_ack16");
    cyc(4'h1, 3'b000, 1'b0, z(), "late_d");
    cyc(4'h1, 3'b000, 1'b0, e_alu(), "late_e");
    cyc(4'h1, 3'b000, 1'b0, wb(0), "late_wb");

    cyc(4'hF, 3'b000, 1'b1, f(1), "halt_f");
    cyc(4'hF, 3'b000, 1'b0, z(), "halt_d");
    cyc(4'hE, 3'b000, 1'b1, hlt(0), "halt_1");
    cyc(4'hE, 3'b000, 1'b1, hlt(0), "halt_2");

    rst_n = 1'b0;
    cyc(4'h4, 3'b000, 1'b0, z(), "rst_halt");
    rst_n = 1'b1;
    cyc(4'h4, 3'b000, 1'b1, f(1), "lw2_f");
    cyc(4'h4, 3'b000, 1'b0, z(), "lw2_d");
    cyc(4'h4, 3'b000, 1'b0, z(), "lw2_e");
    cyc(4'h4, 3'b000, 1'b0, m(0, 0), "lw2_m");
    rst_n = 1'b0;
    cyc(4'h4, 3'b000, 1'b1, z(), "rst_mem");
    rst_n = 1'b1;
    cyc(4'h0, 3'b000, 1'b0, f(0), "restart");

    for (int i = 0; i < 15; i++)
      cyc(4'h0, 3'b000, 1'b0, f(0), "to_wait");
    cyc(4'h0, 3'b000, 1'b0, hlt(1), "fault_1");
    cyc(4'h0, 3'b000, 1'b1, hlt(1), "fault_2");

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule
